mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory access unit: a single outstanding load/store between the
// EX/MEM latch and a req/ack memory port, with lane steering and extension.
module mem_access_unit #(
  parameter int NB_DATA      = 32,
  parameter int NB_MEM_CTRL  = 6,
  parameter int NB_DMEM_ADDR = 10,
  parameter int TIMEOUT      = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic [NB_MEM_CTRL-1:0]  i_MEM_control,
  input  logic [NB_DATA-1:0]      i_alu_result,
  input  logic [NB_DATA-1:0]      i_data_write,
  input  logic                    i_halt_detected,
  output logic                    o_dmem_req,
  output logic                    o_dmem_we,
  output logic [NB_DMEM_ADDR-1:0] o_dmem_addr,
  output logic [NB_DATA-1:0]      o_dmem_wdata,
  output logic [3:0]              o_dmem_be,
  input  logic                    i_dmem_ack,
  input  logic [NB_DATA-1:0]      i_dmem_rdata,
  output logic                    o_stall,
  output logic [NB_DATA-1:0]      o_load_data,
  output logic                    o_load_valid,
  output logic                    o_misaligned,
  output logic                    o_timeout,
  output logic                    o_halted
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [1:0]        sz_q;
  logic              uns_q;
  logic [1:0]        off_q;
  logic              hpend_q;

  logic              rd, wr, aligned, live, accept, halt_in;
  logic [1:0]        sz;
  logic [1:0]        off;
  logic [3:0]        be_d;
  logic [NB_DATA-1:0] wdata_d;
  logic [NB_DATA-1:0] sh;
  logic [NB_DATA-1:0] ext_d;
  logic              unused_bits;

  assign rd      = i_MEM_control[4];
  assign wr      = i_MEM_control[3];
  assign sz      = i_MEM_control[1:0];
  assign off     = i_alu_result[1:0];
  assign halt_in = i_valid & i_halt_detected;

  assign aligned = sz[1] ? (off == 2'b00) :
                   sz[0] ? ~off[0] : 1'b1;

  // A halt marker in IDLE is never treated as an access
  assign live    = (state_q == IDLE) & i_valid & (rd | wr) &
                   ~o_halted & ~i_halt_detected;
  assign accept  = live & aligned;
  assign o_stall = accept | (state_q == REQ);

  assign unused_bits = ^{i_MEM_control[NB_MEM_CTRL-1:5],
                         i_alu_result[NB_DATA-1:NB_DMEM_ADDR+2]};

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = i_data_write;
    if (sz == 2'b00) begin
      be_d    = 4'b0001 << off;
      wdata_d = {4{i_data_write[7:0]}};
    end else if (sz == 2'b01) begin
      be_d    = 4'b0011 << {off[1], 1'b0};
      wdata_d = {2{i_data_write[15:0]}};
    end
  end

  always_comb begin
    sh    = i_dmem_rdata >> {off_q, 3'b000};
    ext_d = sh;
    if (sz_q == 2'b00)
      ext_d = {{(NB_DATA-8){~uns_q & sh[7]}}, sh[7:0]};
    else if (sz_q == 2'b01)
      ext_d = {{(NB_DATA-16){~uns_q & sh[15]}}, sh[15:0]};
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sz_q         <= '0;
      uns_q        <= 1'b0;
      off_q        <= '0;
      hpend_q      <= 1'b0;
      o_dmem_req   <= 1'b0;
      o_dmem_we    <= 1'b0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_dmem_be    <= '0;
      o_load_data  <= '0;
      o_load_valid <= 1'b0;
      o_misaligned <= 1'b0;
      o_timeout    <= 1'b0;
      o_halted     <= 1'b0;
    end else begin
      o_load_valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (halt_in) begin
            o_halted <= 1'b1;
          end else if (live && !aligned) begin
            o_misaligned <= 1'b1;
          end else if (accept) begin
            state_q      <= REQ;
            cnt_q        <= '0;
            o_dmem_req   <= 1'b1;
            o_dmem_we    <= wr;
            o_dmem_addr  <= i_alu_result[NB_DMEM_ADDR+1:2];
            o_dmem_wdata <= wdata_d;
            o_dmem_be    <= be_d;
            sz_q         <= sz;
            uns_q        <= i_MEM_control[2];
            off_q        <= off;
          end
        end
        REQ: begin
          if (halt_in) hpend_q <= 1'b1;
          if (i_dmem_ack) begin
            state_q      <= DONE;
            o_dmem_req   <= 1'b0;
            o_load_valid <= ~o_dmem_we;
            if (!o_dmem_we) o_load_data <= ext_d;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q      <= DONE;
            o_dmem_req   <= 1'b0;
            o_timeout    <= 1'b1;
            o_load_valid <= ~o_dmem_we;
            if (!o_dmem_we) o_load_data <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          hpend_q <= 1'b0;
          if (hpend_q || halt_in) o_halted <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: table of single accesses plus
// sequences for misalignment, timeout, async reset and halt.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [5:0]  ctrl;
  logic [31:0] alu, wdat;
  logic        halt;
  logic        req, we;
  logic [9:0]  daddr;
  logic [31:0] dwdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;
  logic        stall;
  logic [31:0] ldata;
  logic        lvalid, mis, tmo, halted;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .i_clock(clk), .i_reset(rst), .i_valid(valid),
    .i_MEM_control(ctrl), .i_alu_result(alu),
    .i_data_write(wdat), .i_halt_detected(halt),
    .o_dmem_req(req), .o_dmem_we(we), .o_dmem_addr(daddr),
    .o_dmem_wdata(dwdata), .o_dmem_be(be),
    .i_dmem_ack(ack), .i_dmem_rdata(rdata),
    .o_stall(stall), .o_load_data(ldata),
    .o_load_valid(lvalid), .o_misaligned(mis),
    .o_timeout(tmo), .o_halted(halted)
  );

  typedef struct {
    logic [5:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  ebe;
    logic [31:0] ewdata;
    logic [9:0]  eaddr;
    logic        ewe;
    logic        elv;
    logic [31:0] eld;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v, input string tag);
    valid = 1'b1; ctrl = v.ctrl; alu = v.addr; wdat = v.wdata;
    #1;
    chk({tag, " stall0"}, 32'(stall), 32'd1);
    step();
    valid = 1'b0; ctrl = '0;
    chk({tag, " req"}, 32'(req), 32'd1);
    chk({tag, " we"}, 32'(we), 32'(v.ewe));
    chk({tag, " addr"}, 32'(daddr), 32'(v.eaddr));
    chk({tag, " be"}, 32'(be), 32'(v.ebe));
    if (v.ewe) chk({tag, " wdata"}, dwdata, v.ewdata);
    chk({tag, " stall1"}, 32'(stall), 32'd1);
    ack = 1'b1; rdata = v.rdata;
    step();
    ack = 1'b0;
    chk({tag, " lvalid"}, 32'(lvalid), 32'(v.elv));
    if (v.elv) chk({tag, " ldata"}, ldata, v.eld);
    chk({tag, " req_done"}, 32'(req), 32'd0);
    chk({tag, " stall_done"}, 32'(stall), 32'd0);
    step();
    chk({tag, " lvalid_off"}, 32'(lvalid), 32'd0);
  endtask

  vec_t tbl[11];
  vec_t lw0;
  int   n;

  initial begin
    tbl[0]  = '{6'b010000, 32'h6,   32'h0,        32'h80FF1234,
                4'b0100, 32'h0,        10'd1,     1'b0, 1'b1, 32'hFFFFFFFF};
    tbl[1]  = '{6'b010100, 32'h3,   32'h0,        32'h80FF1234,
                4'b1000, 32'h0,        10'd0,     1'b0, 1'b1, 32'h00000080};
    tbl[2]  = '{6'b010001, 32'h2,   32'h0,        32'h80FF1234,
                4'b1100, 32'h0,        10'd0,     1'b0, 1'b1, 32'hFFFF80FF};
    tbl[3]  = '{6'b010101, 32'h0,   32'h0,        32'h80FF9234,
                4'b0011, 32'h0,        10'd0,     1'b0, 1'b1, 32'h00009234};
    tbl[4]  = '{6'b010010, 32'h10,  32'h0,        32'hDEADBEEF,
                4'b1111, 32'h0,        10'd4,     1'b0, 1'b1, 32'hDEADBEEF};
    tbl[5]  = '{6'b001001, 32'h2,   32'h0000ABCD, 32'h0,
                4'b1100, 32'hABCDABCD, 10'd0,     1'b1, 1'b0, 32'h0};
    tbl[6]  = '{6'b001000, 32'h1,   32'h12345678, 32'h0,
                4'b0010, 32'h78787878, 10'd0,     1'b1, 1'b0, 32'h0};
    tbl[7]  = '{6'b001010, 32'hFFC, 32'hCAFEBABE, 32'h0,
                4'b1111, 32'hCAFEBABE, 10'h3FF,   1'b1, 1'b0, 32'h0};
    tbl[8]  = '{6'b011010, 32'h4,   32'h11223344, 32'hFFFFFFFF,
                4'b1111, 32'h11223344, 10'd1,     1'b1, 1'b0, 32'h0};
    tbl[9]  = '{6'b010000, 32'h0,   32'h0,        32'h0000007F,
                4'b0001, 32'h0,        10'd0,     1'b0, 1'b1, 32'h0000007F};
    tbl[10] = '{6'b010001, 32'h402, 32'h0,        32'h7FFF0000,
                4'b1100, 32'h0,        10'h100,   1'b0, 1'b1, 32'h00007FFF};
    lw0     = '{6'b010010, 32'h0,   32'h0,        32'h55AA33CC,
                4'b1111, 32'h0,        10'd0,     1'b0, 1'b1, 32'h55AA33CC};

    rst = 1'b1; valid = 1'b0; ctrl = '0; alu = '0; wdat = '0;
    halt = 1'b0; ack = 1'b0; rdata = '0;
    step(); step();
    chk("rst req", 32'(req), 32'd0);
    chk("rst stall", 32'(stall), 32'd0);
    chk("rst be", 32'(be), 32'd0);
    chk("rst flags", {29'd0, mis, tmo, halted}, 32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 11; i++) run(tbl[i], $sformatf("vec%0d", i));

    // no-op: live entry with neither read nor write
    valid = 1'b1; ctrl = 6'b000010; alu = 32'h8;
    #1;
    chk("noop stall", 32'(stall), 32'd0);
    step();
    valid = 1'b0;
    chk("noop req", 32'(req), 32'd0);
    chk("noop lvalid", 32'(lvalid), 32'd0);

    // misaligned LW
    valid = 1'b1; ctrl = 6'b010010; alu = 32'h5;
    #1;
    chk("mis stall0", 32'(stall), 32'd0);
    step();
    valid = 1'b0; ctrl = '0;
    chk("mis flag", 32'(mis), 32'd1);
    chk("mis req", 32'(req), 32'd0);
    chk("mis stall1", 32'(stall), 32'd0);
    step();
    chk("mis lvalid", 32'(lvalid), 32'd0);
    chk("mis sticky", 32'(mis), 32'd1);

    // LHU with no ack: expect 16 REQ cycles then a zero result
    valid = 1'b1; ctrl = 6'b010101; alu = 32'h2; rdata = 32'hFFFFFFFF;
    step();
    valid = 1'b0; ctrl = '0;
    n = 0;
    while (req && n < 40) begin
      n++;
      step();
    end
    chk("tmo cycles", 32'(n), 32'd16);
    chk("tmo flag", 32'(tmo), 32'd1);
    chk("tmo lvalid", 32'(lvalid), 32'd1);
    chk("tmo ldata", ldata, 32'd0);
    step();
    chk("tmo idle lv", 32'(lvalid), 32'd0);
    chk("tmo idle stall", 32'(stall), 32'd0);

    // async reset in the third REQ cycle
    valid = 1'b1; ctrl = 6'b010010; alu = 32'h0;
    step();
    valid = 1'b0; ctrl = '0;
    step(); step();
    chk("rq3 req", 32'(req), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst req", 32'(req), 32'd0);
    chk("arst stall", 32'(stall), 32'd0);
    chk("arst flags", {29'd0, mis, tmo, halted}, 32'd0);
    #1;
    rst = 1'b0;
    step();
    run(lw0, "lw_after_rst");

    // halt arriving while a load is in flight
    valid = 1'b1; ctrl = 6'b010010; alu = 32'h8;
    step();
    ctrl = '0; halt = 1'b1; ack = 1'b1; rdata = 32'h01020304;
    step();
    valid = 1'b0; halt = 1'b0; ack = 1'b0;
    chk("hflt lvalid", 32'(lvalid), 32'd1);
    chk("hflt ldata", ldata, 32'h01020304);
    step();
    chk("hflt halted", 32'(halted), 32'd1);
    valid = 1'b1; ctrl = 6'b010010; alu = 32'h0;
    #1;
    chk("halted stall", 32'(stall), 32'd0);
    step();
    valid = 1'b0; ctrl = '0;
    chk("halted req", 32'(req), 32'd0);

    // halt marker in IDLE
    rst = 1'b1;
    step();
    rst = 1'b0;
    valid = 1'b1; halt = 1'b1; ctrl = 6'b010010;
    #1;
    chk("hidle stall", 32'(stall), 32'd0);
    step();
    valid = 1'b0; halt = 1'b0; ctrl = '0;
    chk("hidle halted", 32'(halted), 32'd1);
    chk("hidle req", 32'(req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
